// File: rtl/booth_ctrl.sv
// booth_ctrl: control unit for a radix-2 Booth multiplier datapath.
//
// Sequences LOAD, then N rounds of EVAL (add/subtract chosen from the Booth
// pair {Q0,Qm1}) followed by SHIFT, then parks in DONE with Fin raised until
// the requester drops Start. All outputs are decoded from the state register,
// so an asynchronous reset forces every output low in the same cycle.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous reset, active low
//   Start      multiply request level (only looked at in IDLE and DONE)
//   Q0, Qm1    Booth pair from the datapath
//   ResetA / CargaA / DesplazaA    register A commands
//   CargaQ / DesplazaQ             register Q commands
//   CargaM                         register M load
//   ResetQm1 / CargaQm1            Q-1 flip-flop commands
//   Resta      adder op select (1 = A-M), qualified by CargaA
//   Busy       high from LOAD through the last SHIFT
//   Fin        product valid in {A,Q}; held until Start falls
module booth_ctrl #(
  parameter  int N     = 4,
  localparam int CNT_W = $clog2(N+1)
) (
  input  logic clk,
  input  logic reset,
  input  logic Start,
  input  logic Q0,
  input  logic Qm1,
  output logic ResetA,
  output logic CargaA,
  output logic DesplazaA,
  output logic CargaQ,
  output logic DesplazaQ,
  output logic CargaM,
  output logic ResetQm1,
  output logic CargaQm1,
  output logic Resta,
  output logic Busy,
  output logic Fin
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    EVAL  = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_inc;
  logic             last_iter;

  assign count_inc = count + 1'b1;
  assign last_iter = (count_inc == CNT_W'(N));

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // iteration counter: cleared on entry to a run, bumped once per shift;
  // it is left alone in DONE so it never runs past N
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)              count <= '0;
    else if (state == LOAD)  count <= '0;
    else if (state == SHIFT) count <= count_inc;
  end

  // next state and command decode
  always_comb begin
    state_nxt = state;
    ResetA    = 1'b0;
    CargaA    = 1'b0;
    DesplazaA = 1'b0;
    CargaQ    = 1'b0;
    DesplazaQ = 1'b0;
    CargaM    = 1'b0;
    ResetQm1  = 1'b0;
    CargaQm1  = 1'b0;
    Resta     = 1'b0;
    Busy      = 1'b0;
    Fin       = 1'b0;
    case (state)
      IDLE: begin
        if (Start) state_nxt = LOAD;
      end
      LOAD: begin
        ResetA    = 1'b1;
        CargaQ    = 1'b1;
        CargaM    = 1'b1;
        ResetQm1  = 1'b1;
        Busy      = 1'b1;
        state_nxt = EVAL;
      end
      EVAL: begin
        Busy = 1'b1;
        // 10: start of a run of ones -> subtract; 01: end of run -> add
        if (Q0 != Qm1) begin
          CargaA = 1'b1;
          Resta  = Q0;
        end
        state_nxt = SHIFT;
      end
      SHIFT: begin
        DesplazaA = 1'b1;
        DesplazaQ = 1'b1;
        CargaQm1  = 1'b1;
        Busy      = 1'b1;
        state_nxt = last_iter ? DONE : EVAL;
      end
      DONE: begin
        Fin = 1'b1;
        // Fin is a level: wait for the requester to release Start, and any
        // new request must pass through IDLE and LOAD again
        if (!Start) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_booth_ctrl.sv
module tb_booth_ctrl;
  localparam int N = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic Start = 1'b0;
  logic Q0, Qm1;
  logic ResetA, CargaA, DesplazaA, CargaQ, DesplazaQ, CargaM;
  logic ResetQm1, CargaQm1, Resta, Busy, Fin;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  booth_ctrl #(.N(N)) dut (
    .clk(clk), .reset(reset), .Start(Start), .Q0(Q0), .Qm1(Qm1),
    .ResetA(ResetA), .CargaA(CargaA), .DesplazaA(DesplazaA),
    .CargaQ(CargaQ), .DesplazaQ(DesplazaQ), .CargaM(CargaM),
    .ResetQm1(ResetQm1), .CargaQm1(CargaQm1), .Resta(Resta),
    .Busy(Busy), .Fin(Fin)
  );

  // behavioural datapath; A carries one guard bit so -2^(N-1) * -2^(N-1) fits
  logic [N:0]   A = '0;
  logic [N-1:0] Q = '0, M = '0;
  logic         qm1 = 1'b0;
  logic [N-1:0] m_in = '0, q_in = '0;

  assign Q0  = Q[0];
  assign Qm1 = qm1;

  always @(posedge clk) begin
    if (ResetA)         A <= '0;
    else if (CargaA)    A <= Resta ? A - {M[N-1], M} : A + {M[N-1], M};
    else if (DesplazaA) A <= {A[N], A[N:1]};
    if (CargaQ)         Q <= q_in;
    else if (DesplazaQ) Q <= {A[0], Q[N-1:1]};
    if (CargaM)         M <= m_in;
    if (ResetQm1)       qm1 <= 1'b0;
    else if (CargaQm1)  qm1 <= Q[0];
  end

  logic [10:0] outs;
  assign outs = {ResetA, CargaA, DesplazaA, CargaQ, DesplazaQ, CargaM,
                 ResetQm1, CargaQm1, Resta, Busy, Fin};

  // codes per EVAL, first iteration in [7:6]: 11 = SUB, 10 = ADD, 00 = none
  task automatic run_booth(input string nm, input logic [3:0] m, input logic [3:0] q,
                           input logic [7:0] exp_p, input logic [7:0] exp_codes,
                           input bit hold);
    int busy_n = 0;
    int fin_cyc = 0;
    int ev = 0;
    logic [7:0] codes = '0;
    bit excl = 1'b0;
    m_in = m;
    q_in = q;
    Start = 1'b1;
    for (int c = 1; c <= 30 && fin_cyc == 0; c++) begin
      @(negedge clk);
      if (!hold) Start = 1'b0;
      if ((CargaA && DesplazaA) || (CargaQ && DesplazaQ)) excl = 1'b1;
      if (Busy) busy_n++;
      if (Busy && !ResetA && !DesplazaA && ev < 4) begin
        codes[7-2*ev -: 2] = {CargaA, Resta};
        ev++;
      end
      if (Fin) fin_cyc = c;
    end
    total++;
    if (busy_n !== 9) begin
      bad++; $display("FAIL %s busy_cycles: got %0d want 9", nm, busy_n);
    end
    total++;
    if (fin_cyc !== 10) begin
      bad++; $display("FAIL %s fin_cycle: got %0d want 10", nm, fin_cyc);
    end
    total++;
    if (codes !== exp_codes) begin
      bad++; $display("FAIL %s eval_cmds: got %b want %b", nm, codes, exp_codes);
    end
    total++;
    if ({A[N-1:0], Q} !== exp_p) begin
      bad++; $display("FAIL %s product: got %b want %b", nm, {A[N-1:0], Q}, exp_p);
    end
    total++;
    if (excl !== 1'b0) begin
      bad++; $display("FAIL %s exclusivity: got 1 want 0", nm);
    end
    if (!hold) begin
      @(negedge clk);
      total++;
      if (outs !== 11'h000) begin
        bad++; $display("FAIL %s back_to_idle: got %b want %b", nm, outs, 11'h000);
      end
    end
  endtask

  task automatic test_reset();
    #1;
    total++;
    if (outs !== 11'h000) begin
      bad++; $display("FAIL reset_outs: got %b want %b", outs, 11'h000);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (outs !== 11'h000) begin
        bad++; $display("FAIL reset_idle%0d: got %b want %b", i, outs, 11'h000);
      end
    end
  endtask

  task automatic test_mult();
    run_booth("3x5",   4'b0011, 4'b0101, 8'b0000_1111, 8'b11_10_11_10, 1'b0);
    run_booth("3xm2",  4'b0011, 4'b1110, 8'b1111_1010, 8'b00_11_00_00, 1'b0);
    run_booth("m8xm8", 4'b1000, 4'b1000, 8'b0100_0000, 8'b00_00_00_11, 1'b0);
  endtask

  task automatic test_start_held();
    run_booth("held", 4'b0010, 4'b0010, 8'b0000_0100, 8'b00_11_10_00, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (outs !== 11'h001) begin
        bad++; $display("FAIL held_fin%0d: got %b want %b", i, outs, 11'h001);
      end
    end
  endtask

  task automatic test_back_to_back();
    Start = 1'b0;
    @(negedge clk);
    total++;
    if (outs !== 11'h000) begin
      bad++; $display("FAIL b2b_idle: got %b want %b", outs, 11'h000);
    end
    run_booth("b2b", 4'b1010, 4'b0011, 8'b1110_1110, 8'b11_00_10_00, 1'b0);
  endtask

  task automatic test_reset_mid();
    int shifts = 0;
    bit hit = 1'b0;
    m_in = 4'b0101;
    q_in = 4'b0110;
    Start = 1'b1;
    for (int c = 0; c < 20 && !hit; c++) begin
      @(negedge clk);
      Start = 1'b0;
      if (DesplazaA) shifts++;
      if (shifts == 2) hit = 1'b1;
    end
    total++;
    if (hit !== 1'b1) begin
      bad++; $display("FAIL mid_shift_reached: got 0 want 1");
    end
    reset = 1'b0;
    #1;
    total++;
    if (outs !== 11'h000) begin
      bad++; $display("FAIL mid_reset_outs: got %b want %b", outs, 11'h000);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++;
      if (outs !== 11'h000) begin
        bad++; $display("FAIL mid_reset_idle%0d: got %b want %b", i, outs, 11'h000);
      end
    end
  endtask

  task automatic test_after_reset();
    run_booth("7xm3", 4'b0111, 4'b1101, 8'b1110_1011, 8'b11_10_11_00, 1'b0);
  endtask

  initial begin
    test_reset();
    test_mult();
    test_start_held();
    test_back_to_back();
    test_reset_mid();
    test_after_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
